// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control path: opcodes, FSM state codes,
// ALU operation codes and the bundle of registered control outputs.
package ctrl_pkg;

  localparam logic [6:0] OPCODE_R  = 7'b0110011;
  localparam logic [6:0] OPCODE_I  = 7'b0010011;
  localparam logic [6:0] OPCODE_LW = 7'b0000011;
  localparam logic [6:0] OPCODE_S  = 7'b0100011;
  localparam logic [6:0] OPCODE_B  = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef struct packed {
    logic       pc_src;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic [3:0] alu_ctrl;
    logic       load_pc;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from {opcode, funct3, funct7[5]} to the ALU operation code
// and a flag saying whether the instruction is supported at all.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_AND;
    legal_o    = 1'b0;
    case (opcode_i)
      OPCODE_R, OPCODE_I: begin
        legal_o = 1'b1;
        case (funct3_i)
          3'b000:  alu_ctrl_o = (opcode_i == OPCODE_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  legal_o    = 1'b0;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      OPCODE_LW, OPCODE_S: begin
        legal_o    = 1'b1;
        alu_ctrl_o = ALU_ADD;
      end
      OPCODE_B: begin
        // Only BEQ and BNE are implemented.
        legal_o    = (funct3_i == 3'b000) || (funct3_i == 3'b001);
        alu_ctrl_o = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer driving the datapath control inputs,
// with registered Moore outputs and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // iReady qualifies instr and is only consumed in IF; dReady completes a
  // MemRead/MemWrite request and is only consumed in MEM.
  input  logic [31:0]              instr,
  input  logic                     iReady,
  input  logic                     dReady,
  input  logic                     zero,
  output logic                     PCSrc,
  output logic                     ALUSrc,
  output logic                     RegWrite,
  output logic                     MemtoReg,
  output logic [3:0]               ALUCtrl,
  output logic                     loadPC,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     illegal,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic [2:0]               state
);

  state_e                   state_q, state_d;
  logic [31:0]              instr_q, instr_d;
  logic                     taken_q, taken_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  ctrl_out_t                out_q, out_d;

  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       is_r, is_i, is_lw, is_sw, is_b;
  logic       unused_instr_bits;

  alu_decoder u_alu_decoder (
    .opcode_i   (instr_q[6:0]),
    .funct3_i   (instr_q[14:12]),
    .funct7_5_i (instr_q[30]),
    .alu_ctrl_o (dec_alu),
    .legal_o    (dec_legal)
  );

  assign is_r  = (instr_q[6:0] == OPCODE_R);
  assign is_i  = (instr_q[6:0] == OPCODE_I);
  assign is_lw = (instr_q[6:0] == OPCODE_LW);
  assign is_sw = (instr_q[6:0] == OPCODE_S);
  assign is_b  = (instr_q[6:0] == OPCODE_B);

  // Register and immediate fields belong to the datapath.
  assign unused_instr_bits = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    taken_d   = taken_q;
    instret_d = instret_q;
    case (state_q)
      ST_IF: begin
        if (iReady) begin
          instr_d = instr;
          taken_d = 1'b0;
          state_d = ST_ID;
        end
      end
      ST_ID:  state_d = dec_legal ? ST_EX : ST_WB;
      ST_EX: begin
        if (is_b) taken_d = instr_q[12] ? ~zero : zero;
        state_d = (is_lw || is_sw) ? ST_MEM : ST_WB;
      end
      ST_MEM: if (dReady) state_d = ST_WB;
      ST_WB:  state_d = ST_IF;
      default: state_d = ST_IF;
    endcase
    if (state_d == ST_WB) instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
  end

  // Outputs are decoded from the next state so that, once registered, they line
  // up with the state they belong to. instr_q never changes on entry to EX..WB.
  always_comb begin
    out_d = '0;
    if ((state_d == ST_EX || state_d == ST_MEM || state_d == ST_WB) && dec_legal) begin
      out_d.alu_ctrl = dec_alu;
      out_d.alu_src  = is_i || is_lw || is_sw;
    end
    if (state_d == ST_MEM) begin
      out_d.mem_read  = is_lw;
      out_d.mem_write = is_sw;
    end
    if (state_d == ST_WB) begin
      out_d.load_pc    = 1'b1;
      out_d.pc_src     = dec_legal && is_b && taken_d;
      out_d.reg_write  = dec_legal && (is_r || is_i || is_lw);
      out_d.mem_to_reg = dec_legal && is_lw;
      out_d.illegal    = ~dec_legal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IF;
      instr_q   <= '0;
      taken_q   <= 1'b0;
      instret_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      taken_q   <= taken_d;
      instret_q <= instret_d;
      out_q     <= out_d;
    end
  end

  assign PCSrc    = out_q.pc_src;
  assign ALUSrc   = out_q.alu_src;
  assign RegWrite = out_q.reg_write;
  assign MemtoReg = out_q.mem_to_reg;
  assign ALUCtrl  = out_q.alu_ctrl;
  assign loadPC   = out_q.load_pc;
  assign MemRead  = out_q.mem_read;
  assign MemWrite = out_q.mem_write;
  assign illegal  = out_q.illegal;
  assign instret  = instret_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: the driver pushes per-instruction
// expectations from a reference model, the monitor pops them at each loadPC.
module tb_multicycle_ctrl;

  localparam int IW = 4;

  typedef struct packed {
    logic          pc_src;
    logic          alu_src;
    logic          reg_write;
    logic          mem_to_reg;
    logic [3:0]    alu_ctrl;
    logic          illegal;
    logic [IW-1:0] instret;
    logic [7:0]    rd_cyc;
    logic [7:0]    wr_cyc;
    logic [31:0]   wb_cyc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic          clk, rst;
  logic [31:0]   instr;
  logic          iReady, dReady, zero;
  logic          PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite, illegal;
  logic [3:0]    ALUCtrl;
  logic [IW-1:0] instret;
  logic [2:0]    state;

  logic [EXP_W-1:0] exp_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic          rst_chk, if_window, final_chk;
  logic [IW-1:0] model_instret, final_instret;
  exp_t          mon_e;

  multicycle_ctrl #(.INSTRET_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .iReady(iReady), .dReady(dReady), .zero(zero),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .instret(instret), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 4'b0010;
      3'd1: return 4'b1001;
      3'd2: return 4'b0111;
      3'd4: return 4'b1101;
      3'd5: return 4'b1000;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic z, input int dwait);
    exp_t e;
    logic [2:0] f3;
    logic f7, legal;
    e = '0;
    f3 = ins[14:12];
    f7 = ins[30];
    legal = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        legal = (f3 != 3'd3);
        e.alu_ctrl = (f7 && f3 == 3'd0) ? 4'b0110 : (f7 && f3 == 3'd5) ? 4'b1010 : f3_op(f3);
        e.reg_write = 1'b1;
      end
      7'b0010011: begin
        legal = (f3 != 3'd3);
        e.alu_ctrl = (f7 && f3 == 3'd5) ? 4'b1010 : f3_op(f3);
        e.alu_src = 1'b1;
        e.reg_write = 1'b1;
      end
      7'b0000011: begin
        legal = 1'b1;
        e.alu_ctrl = 4'b0010;
        e.alu_src = 1'b1;
        e.reg_write = 1'b1;
        e.mem_to_reg = 1'b1;
        e.rd_cyc = 8'(dwait + 1);
      end
      7'b0100011: begin
        legal = 1'b1;
        e.alu_ctrl = 4'b0010;
        e.alu_src = 1'b1;
        e.wr_cyc = 8'(dwait + 1);
      end
      7'b1100011: begin
        legal = (f3 < 3'd2);
        e.alu_ctrl = 4'b0110;
        e.pc_src = (f3 == 3'd0) ? z : ~z;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: begin w[6:0] = 7'b1100011; w[14:13] = 2'b00; end
      5: w[6:0] = 7'b1100011;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_instr(input logic [31:0] ins, input logic z, input int dwait, input int idle);
    exp_t e;
    int lat;
    bit mem;
    for (int k = 0; k < idle; k++) begin
      iReady = 1'b0;
      instr = $urandom;
      dReady = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    e = model(ins, z, dwait);
    mem = (e.rd_cyc != 0) || (e.wr_cyc != 0);
    lat = e.illegal ? 3 : (mem ? 5 + dwait : 4);
    model_instret = model_instret + 1'b1;
    e.instret = model_instret;
    e.wb_cyc = cyc + lat - 1;
    exp_q.push_back(EXP_W'(e));
    for (int k = 0; k < lat; k++) begin
      iReady = (k == 0);
      instr = (k == 0) ? ins : $urandom;
      zero = (k == 2) ? z : ~z;
      if (mem && k >= 3) dReady = (k == 3 + dwait);
      else dReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if_window = 1'b0;
    end
    if_window = 1'b1;
  endtask

  task automatic abort_instr(input logic [31:0] ins, input int edges);
    iReady = 1'b1;
    instr = ins;
    dReady = 1'b0;
    zero = 1'b0;
    @(posedge clk); #1;
    if_window = 1'b0;
    iReady = 1'b0;
    for (int k = 1; k < edges; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    rst_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_instret = '0;
    repeat (2) @(posedge clk);
    #1 rst_chk = 1'b0;
    if_window = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_chk) begin
      check("rst_ctrl", 64'({PCSrc, ALUSrc, RegWrite, MemtoReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal}), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_instret", 64'(instret), 64'd0);
      rd_cnt = 0;
      wr_cnt = 0;
    end else if (rst) begin
      if (if_window)
        check("if_quiet", 64'({ALUCtrl, ALUSrc, MemRead, MemWrite, loadPC}), 64'd0);
      if (MemRead || MemWrite) begin
        rd_cnt += int'(MemRead);
        wr_cnt += int'(MemWrite);
        if (exp_q.size() > 0) begin
          mon_e = exp_t'(exp_q[0]);
          check("mem_aluctrl", 64'(ALUCtrl), 64'(mon_e.alu_ctrl));
        end
      end
      if (loadPC) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 64'd1, 64'd0);
        end else begin
          mon_e = exp_t'(exp_q.pop_front());
          check("wb_pcsrc", 64'(PCSrc), 64'(mon_e.pc_src));
          check("wb_alusrc", 64'(ALUSrc), 64'(mon_e.alu_src));
          check("wb_regwrite", 64'(RegWrite), 64'(mon_e.reg_write));
          check("wb_memtoreg", 64'(MemtoReg), 64'(mon_e.mem_to_reg));
          check("wb_aluctrl", 64'(ALUCtrl), 64'(mon_e.alu_ctrl));
          check("wb_illegal", 64'(illegal), 64'(mon_e.illegal));
          check("wb_instret", 64'(instret), 64'(mon_e.instret));
          check("mem_read_cycles", 64'(rd_cnt), 64'(mon_e.rd_cyc));
          check("mem_write_cycles", 64'(wr_cnt), 64'(mon_e.wr_cyc));
          check("wb_cycle", 64'(cyc), 64'(mon_e.wb_cyc));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        check("non_wb_quiet", 64'({PCSrc, RegWrite, MemtoReg, illegal}), 64'd0);
      end
    end
    if (final_chk) begin
      check("leftover_expectations", 64'(exp_q.size()), 64'd0);
      check("final_instret", 64'(instret), 64'(final_instret));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    iReady = 1'b0;
    instr = '0;
    dReady = 1'b0;
    zero = 1'b0;
    rst_chk = 1'b1;
    if_window = 1'b1;
    final_chk = 1'b0;
    model_instret = '0;
    final_instret = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_chk = 1'b0;

    run_instr(32'h002081B3, 1'b0, 0, 0);  // ADD x3,x1,x2
    run_instr(32'h0080A283, 1'b0, 3, 1);  // LW x5,8(x1), dReady late
    run_instr(32'h00208063, 1'b1, 0, 0);  // BEQ, zero=1 -> taken
    run_instr(32'h00209063, 1'b1, 0, 0);  // BNE, zero=1 -> not taken
    run_instr(32'h0000007F, 1'b0, 0, 0);  // unsupported opcode
    run_instr(32'h0020A423, 1'b0, 2, 0);  // SW

    abort_instr(32'h002081B3, 2);  // reset while in EX
    abort_instr(32'h0020A423, 3);  // reset while in MEM

    for (int i = 0; i < 15; i++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
    run_instr(32'h0020A423, 1'b0, 0, 0);  // 16th since reset: counter wraps to 0

    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));

    iReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 final_instret = model_instret;
    final_chk = 1'b1;
    @(posedge clk);
    #1 final_chk = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
